// File: rtl/ifetch_pc_unit.sv
// Fetch stage of the 16-bit multicycle core: owns PC and IR, fetches over a req/ready
// handshake with timeout, and applies controller jump/branch PC updates while idle.
module ifetch_pc_unit #(
   parameter int                 ADDR_W   = 16,
   parameter int                 DATA_W   = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int                 TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic              pc_write,
   input  logic [1:0]        pc_src,
   input  logic              beq_cond,
   input  logic              bnq_cond,
   input  logic              alu_zero,
   input  logic [ADDR_W-1:0] alu_result,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic [3:0]        opcode,
   output logic [3:0]        func_field,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_busy,
   output logic              ir_valid,
   output logic              fetch_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic              r_ir_valid, r_err;
   logic              w_br, w_load, w_nop, w_start;

   assign w_br = (beq_cond & alu_zero) | (bnq_cond & ~alu_zero);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_nop   = 1'b0;
      w_start = 1'b0;
      case (r_state)
         IDLE: if (fetch_req) begin
            w_next  = REQ;
            w_start = 1'b1;
         end
         REQ: begin
            if (imem_ready) begin
               w_load = 1'b1;
               w_next = IDLE;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_next = ERR;
            end
         end
         ERR: begin
            w_nop  = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_cnt      <= '0;
         r_ir_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ir_valid <= w_load | w_nop;
         if (w_start)                     r_cnt <= '0;
         else if (r_state == REQ)         r_cnt <= r_cnt + CW'(1);
         if (w_load) begin
            r_ir <= imem_rdata;
            r_pc <= r_pc + ADDR_W'(1);
         end
         if (w_nop) begin
            r_ir  <= '0;
            r_err <= 1'b1;
         end
         // Controller PC updates only when idle and not starting a fetch.
         if (r_state == IDLE && !fetch_req) begin
            if (w_br)
               r_pc <= alu_result;
            else if (pc_write && pc_src == 2'b01)
               r_pc <= {r_pc[ADDR_W-1:12], r_ir[11:0]};
            else if (pc_write && pc_src == 2'b10)
               r_pc <= alu_result;
         end
      end
   end

   assign imem_req   = (r_state == REQ);
   assign fetch_busy = (r_state == REQ);
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign ir         = r_ir;
   assign opcode     = r_ir[15:12];
   assign func_field = r_ir[3:0];
   assign ir_valid   = r_ir_valid;
   assign fetch_err  = r_err;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Directed bench for ifetch_pc_unit: fetch latency, wait states, timeout, jumps, branches,
// PC wrap and async reset mid-fetch.
module tb_ifetch_pc_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic        fetch_req = 0, pc_write = 0, beq_cond = 0, bnq_cond = 0, alu_zero = 0;
   logic [1:0]  pc_src = 2'b00;
   logic [15:0] alu_result = '0, imem_rdata = '0;
   logic        imem_ready = 0;
   logic        imem_req, fetch_busy, ir_valid, fetch_err;
   logic [15:0] imem_addr, ir, pc;
   logic [3:0]  opcode, func_field;
   int          checks = 0, errors = 0;

   ifetch_pc_unit dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_write(pc_write), .pc_src(pc_src),
      .beq_cond(beq_cond), .bnq_cond(bnq_cond), .alu_zero(alu_zero), .alu_result(alu_result),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode), .func_field(func_field), .pc(pc),
      .fetch_busy(fetch_busy), .ir_valid(ir_valid), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #12;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_req", 16'(imem_req), 16'h0);
      chk("rst_busy", 16'(fetch_busy), 16'h0);
      chk("rst_irv", 16'(ir_valid), 16'h0);
      chk("rst_err", 16'(fetch_err), 16'h0);
      rst = 0;
      tick();

      // fetch with ready in the first REQ cycle
      fetch_req = 1;
      tick();
      fetch_req = 0;
      chk("f1_req", 16'(imem_req), 16'h1);
      chk("f1_addr", imem_addr, 16'h0000);
      chk("f1_irv0", 16'(ir_valid), 16'h0);
      imem_ready = 1; imem_rdata = 16'h8123;
      tick();
      imem_ready = 0;
      chk("f1_ir", ir, 16'h8123);
      chk("f1_op", 16'(opcode), 16'h8);
      chk("f1_func", 16'(func_field), 16'h3);
      chk("f1_pc", pc, 16'h0001);
      chk("f1_irv", 16'(ir_valid), 16'h1);
      chk("f1_busy", 16'(fetch_busy), 16'h0);
      tick();
      chk("f1_irv_pulse", 16'(ir_valid), 16'h0);

      // ready outside REQ is ignored
      imem_ready = 1; imem_rdata = 16'hDEAD;
      tick();
      imem_ready = 0;
      chk("idle_rdy_ir", ir, 16'h8123);
      chk("idle_rdy_pc", pc, 16'h0001);

      // three wait states
      fetch_req = 1;
      tick();
      fetch_req = 0; imem_rdata = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         chk("ws_busy", 16'(fetch_busy), 16'h1);
         chk("ws_addr", imem_addr, 16'h0001);
         tick();
      end
      chk("ws_busy4", 16'(fetch_busy), 16'h1);
      chk("ws_ir_hold", ir, 16'h8123);
      imem_ready = 1; imem_rdata = 16'h1234;
      tick();
      imem_ready = 0;
      chk("ws_ir", ir, 16'h1234);
      chk("ws_pc", pc, 16'h0002);
      chk("ws_busy_done", 16'(fetch_busy), 16'h0);

      // indirect to 5000, fetch 3ABC -> pc 5001, then jump
      pc_write = 1; pc_src = 2'b10; alu_result = 16'h5000;
      tick();
      pc_write = 0;
      chk("ind_pc", pc, 16'h5000);
      fetch_req = 1;
      tick();
      fetch_req = 0; imem_ready = 1; imem_rdata = 16'h3ABC;
      tick();
      imem_ready = 0;
      chk("j_pre_pc", pc, 16'h5001);
      pc_write = 1; pc_src = 2'b01;
      tick();
      chk("jump_pc", pc, 16'h5ABC);
      pc_src = 2'b00;
      tick();
      chk("src00_pc", pc, 16'h5ABC);
      pc_src = 2'b11; alu_result = 16'h9999;
      tick();
      pc_write = 0;
      chk("src11_pc", pc, 16'h5ABC);

      // branches
      beq_cond = 1; alu_zero = 1; alu_result = 16'h0040;
      tick();
      beq_cond = 0;
      chk("beq_pc", pc, 16'h0040);
      bnq_cond = 1; alu_result = 16'h1111;
      tick();
      bnq_cond = 0;
      chk("bnq_nt_pc", pc, 16'h0040);
      bnq_cond = 1; alu_zero = 0; alu_result = 16'h0050;
      pc_write = 1; pc_src = 2'b10; alu_result = 16'h0050;
      tick();
      bnq_cond = 0; pc_write = 0;
      chk("bnq_t_pc", pc, 16'h0050);
      beq_cond = 1; bnq_cond = 1; alu_zero = 0; alu_result = 16'h0040;
      tick();
      beq_cond = 0; bnq_cond = 0;
      chk("both_pc", pc, 16'h0040);

      // fetch_req beats branch; controls ignored during REQ
      fetch_req = 1; beq_cond = 1; alu_zero = 1; alu_result = 16'h7000;
      tick();
      fetch_req = 0; pc_write = 1; pc_src = 2'b10;
      chk("prio_pc", pc, 16'h0040);
      chk("prio_busy", 16'(fetch_busy), 16'h1);
      tick();
      chk("req_ign_pc", pc, 16'h0040);
      beq_cond = 0; pc_write = 0;
      imem_ready = 1; imem_rdata = 16'h7777;
      tick();
      imem_ready = 0;
      chk("prio_fetch_pc", pc, 16'h0041);
      chk("prio_fetch_ir", ir, 16'h7777);

      // timeout: REQ lasts 15 cycles, then ERR for one
      fetch_req = 1;
      tick();
      fetch_req = 0;
      for (int i = 0; i < 14; i++) begin
         chk("to_busy", 16'(fetch_busy), 16'h1);
         tick();
      end
      chk("to_busy15", 16'(fetch_busy), 16'h1);
      tick();
      chk("err_busy", 16'(fetch_busy), 16'h0);
      chk("err_req", 16'(imem_req), 16'h0);
      chk("err_ir_old", ir, 16'h7777);
      chk("err_flag0", 16'(fetch_err), 16'h0);
      tick();
      chk("to_ir", ir, 16'h0000);
      chk("to_pc", pc, 16'h0041);
      chk("to_err", 16'(fetch_err), 16'h1);
      chk("to_irv", 16'(ir_valid), 16'h1);
      tick();
      chk("to_irv_pulse", 16'(ir_valid), 16'h0);

      // pc wrap, error stays sticky
      pc_write = 1; pc_src = 2'b10; alu_result = 16'hFFFF;
      tick();
      pc_write = 0;
      fetch_req = 1;
      tick();
      fetch_req = 0;
      chk("wrap_addr", imem_addr, 16'hFFFF);
      imem_ready = 1; imem_rdata = 16'h2222;
      tick();
      imem_ready = 0;
      chk("wrap_pc", pc, 16'h0000);
      chk("err_sticky", 16'(fetch_err), 16'h1);

      // async reset mid-REQ
      pc_write = 1; pc_src = 2'b10; alu_result = 16'h0300;
      tick();
      pc_write = 0;
      fetch_req = 1;
      tick();
      fetch_req = 0;
      chk("mr_req1", 16'(imem_req), 16'h1);
      #2 rst = 1; imem_ready = 1; imem_rdata = 16'hAAAA;
      #1;
      chk("mr_req0", 16'(imem_req), 16'h0);
      chk("mr_pc", pc, 16'h0000);
      chk("mr_ir", ir, 16'h0000);
      chk("mr_err", 16'(fetch_err), 16'h0);
      tick();
      rst = 0;
      tick();
      imem_ready = 0;
      chk("mr_ir_disc", ir, 16'h0000);
      chk("mr_irv", 16'(ir_valid), 16'h0);
      chk("mr_pc2", pc, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
